// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
//
// Purpose : bundles the instruction-register feedback and every control strobe
//           exchanged between the hardwired sequencer (control_unit) and the
//           Datapath, so both sides see one named connection.
//
// Signals :
//   IRdataout [31:0]  instruction register contents (opcode = [31:27])
//   PCout PCin IncPC MARin Read Write MDRin MDRout IRin   memory/fetch strobes
//   Yin Zin Zlowout Cout BAout ADD                         ALU path strobes
//   Gra Grb Rin Rout                                       register strobes
//   CONin BRANCH                                           branch condition strobes
//   Run                high while an instruction is being sequenced
//   state [3:0]        current sequencer state code (monitoring only)
//
// Modports:
//   master : the sequencer (reads IRdataout, drives everything else)
//   slave  : the datapath side (drives IRdataout, reads the strobes)
// -----------------------------------------------------------------------------
interface control_unit_if;
    logic [31:0] IRdataout;

    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        Read;
    logic        Write;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;

    logic        Yin;
    logic        Zin;
    logic        Zlowout;
    logic        Cout;
    logic        BAout;
    logic        ADD;

    logic        Gra;
    logic        Grb;
    logic        Rin;
    logic        Rout;

    logic        CONin;
    logic        BRANCH;

    logic        Run;
    logic [3:0]  state;

    modport master (
        input  IRdataout,
        output PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Cout, BAout, ADD,
        output Gra, Grb, Rin, Rout,
        output CONin, BRANCH,
        output Run, state
    );

    modport slave (
        output IRdataout,
        input  PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Cout, BAout, ADD,
        input  Gra, Grb, Rin, Rout,
        input  CONin, BRANCH,
        input  Run, state
    );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Purpose : hardwired Moore sequencer for the Datapath. Runs a three-state
//           fetch (T0..T2), decodes the opcode in T3 and walks the
//           opcode-specific execute sequence one state per clock, then
//           returns to T0 with no bubble. A halt instruction parks the
//           machine in HALT until reset.
//
// Ports   :
//   clk   in   system clock, all state changes on the rising edge
//   clr   in   synchronous active-low reset
//   bus   --   control_unit_if.master: IRdataout in, all strobes, Run and
//              state out
//
// State codes: RST=0, T0..T7=1..8, HALT=15. Codes 9..14 are unreachable and
// fall back to RST.
// -----------------------------------------------------------------------------
module control_unit (
    input  logic             clk,
    input  logic             clr,
    control_unit_if.master   bus
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd15;

    // -------------------------------------------------------------------------
    // Opcode encoding (IRdataout[31:27])
    // -------------------------------------------------------------------------
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // -------------------------------------------------------------------------
    // Strobe vector bit positions
    // -------------------------------------------------------------------------
    localparam int NUM_STROBES = 21;

    localparam int IDX_PCOUT   = 20;
    localparam int IDX_PCIN    = 19;
    localparam int IDX_INCPC   = 18;
    localparam int IDX_MARIN   = 17;
    localparam int IDX_READ    = 16;
    localparam int IDX_WRITE   = 15;
    localparam int IDX_MDRIN   = 14;
    localparam int IDX_MDROUT  = 13;
    localparam int IDX_IRIN    = 12;
    localparam int IDX_YIN     = 11;
    localparam int IDX_ZIN     = 10;
    localparam int IDX_ZLOWOUT = 9;
    localparam int IDX_COUT    = 8;
    localparam int IDX_BAOUT   = 7;
    localparam int IDX_ADD     = 6;
    localparam int IDX_GRA     = 5;
    localparam int IDX_GRB     = 4;
    localparam int IDX_RIN     = 3;
    localparam int IDX_ROUT    = 2;
    localparam int IDX_CONIN   = 1;
    localparam int IDX_BRANCH  = 0;

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    logic [3:0]             state_q;
    logic [3:0]             state_d;
    logic [4:0]             opcode_q;
    logic [4:0]             opcode_d;

    logic [4:0]             opcode_cur;   // opcode governing the current state
    logic [3:0]             last_state;   // final execute state of opcode_cur
    logic [NUM_STROBES-1:0] strobes;

    // -------------------------------------------------------------------------
    // Opcode capture
    //
    // The IR is only trusted during T3. The opcode is latched at the end of T3
    // so that later execute states keep sequencing the same instruction even
    // if IRdataout moves afterwards. During T3 itself the live IR is used.
    // -------------------------------------------------------------------------
    always_comb begin
        if (state_q == S_T3) begin
            opcode_cur = bus.IRdataout[31:27];
        end else begin
            opcode_cur = opcode_q;
        end
        opcode_d = opcode_cur;
    end

    // Length of each execute sequence, expressed as the state that ends it.
    always_comb begin
        case (opcode_cur)
            OP_LD,
            OP_ST:   last_state = S_T7;
            OP_LDI,
            OP_ADDI: last_state = S_T5;
            OP_BR:   last_state = S_T6;
            default: last_state = S_T3;   // jr, nop, halt, unlisted opcodes
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3,
            S_T4,
            S_T5,
            S_T6,
            S_T7: begin
                if (state_q == last_state) begin
                    // halt only ever ends at T3, so this check is enough
                    if (opcode_cur == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = state_q + 4'd1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers, synchronous active-low reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_RST;
            opcode_q <= OP_NOP;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // -------------------------------------------------------------------------
    // Strobe decode (Moore: registered state plus latched opcode; only T3
    // looks at the live IR)
    // -------------------------------------------------------------------------
    always_comb begin
        strobes = '0;
        case (state_q)
            S_T0: begin
                strobes[IDX_PCOUT] = 1'b1;
                strobes[IDX_MARIN] = 1'b1;
            end
            S_T1: begin
                strobes[IDX_INCPC] = 1'b1;
                strobes[IDX_READ]  = 1'b1;
                strobes[IDX_MDRIN] = 1'b1;
            end
            S_T2: begin
                strobes[IDX_MDROUT] = 1'b1;
                strobes[IDX_IRIN]   = 1'b1;
            end
            S_T3,
            S_T4,
            S_T5,
            S_T6,
            S_T7: begin
                case (opcode_cur)
                    // ld and st share the effective-address computation
                    // (T3..T5); they differ only in the data transfer.
                    OP_LD,
                    OP_ST: begin
                        case (state_q)
                            S_T3: begin
                                strobes[IDX_GRB]   = 1'b1;
                                strobes[IDX_BAOUT] = 1'b1;
                                strobes[IDX_YIN]   = 1'b1;
                            end
                            S_T4: begin
                                strobes[IDX_COUT] = 1'b1;
                                strobes[IDX_ADD]  = 1'b1;
                                strobes[IDX_ZIN]  = 1'b1;
                            end
                            S_T5: begin
                                strobes[IDX_ZLOWOUT] = 1'b1;
                                strobes[IDX_MARIN]   = 1'b1;
                            end
                            S_T6: begin
                                if (opcode_cur == OP_LD) begin
                                    strobes[IDX_READ]  = 1'b1;
                                    strobes[IDX_MDRIN] = 1'b1;
                                end else begin
                                    strobes[IDX_GRA]   = 1'b1;
                                    strobes[IDX_ROUT]  = 1'b1;
                                    strobes[IDX_MDRIN] = 1'b1;
                                end
                            end
                            S_T7: begin
                                if (opcode_cur == OP_LD) begin
                                    strobes[IDX_MDROUT] = 1'b1;
                                    strobes[IDX_GRA]    = 1'b1;
                                    strobes[IDX_RIN]    = 1'b1;
                                end else begin
                                    strobes[IDX_WRITE] = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end

                    // ldi and addi differ only in what feeds Y at T3:
                    // base-address form (R0 reads as zero) vs. plain Rb.
                    OP_LDI,
                    OP_ADDI: begin
                        case (state_q)
                            S_T3: begin
                                strobes[IDX_GRB] = 1'b1;
                                strobes[IDX_YIN] = 1'b1;
                                if (opcode_cur == OP_LDI) begin
                                    strobes[IDX_BAOUT] = 1'b1;
                                end else begin
                                    strobes[IDX_ROUT] = 1'b1;
                                end
                            end
                            S_T4: begin
                                strobes[IDX_COUT] = 1'b1;
                                strobes[IDX_ADD]  = 1'b1;
                                strobes[IDX_ZIN]  = 1'b1;
                            end
                            S_T5: begin
                                strobes[IDX_ZLOWOUT] = 1'b1;
                                strobes[IDX_GRA]     = 1'b1;
                                strobes[IDX_RIN]     = 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    // The taken/not-taken choice is made by the datapath's
                    // CON flip-flop; BRANCH only selects the conditional PC
                    // update path.
                    OP_BR: begin
                        case (state_q)
                            S_T3: begin
                                strobes[IDX_GRA]   = 1'b1;
                                strobes[IDX_ROUT]  = 1'b1;
                                strobes[IDX_CONIN] = 1'b1;
                            end
                            S_T4: begin
                                strobes[IDX_PCOUT] = 1'b1;
                                strobes[IDX_YIN]   = 1'b1;
                            end
                            S_T5: begin
                                strobes[IDX_COUT]   = 1'b1;
                                strobes[IDX_ADD]    = 1'b1;
                                strobes[IDX_BRANCH] = 1'b1;
                                strobes[IDX_ZIN]    = 1'b1;
                            end
                            S_T6: begin
                                strobes[IDX_ZLOWOUT] = 1'b1;
                                strobes[IDX_PCIN]    = 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    OP_JR: begin
                        if (state_q == S_T3) begin
                            strobes[IDX_GRA]  = 1'b1;
                            strobes[IDX_ROUT] = 1'b1;
                            strobes[IDX_PCIN] = 1'b1;
                        end
                    end

                    // nop, halt and unlisted opcodes assert nothing
                    default: ;
                endcase
            end
            // RST, HALT and unreachable codes: everything low
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.PCout   = strobes[IDX_PCOUT];
    assign bus.PCin    = strobes[IDX_PCIN];
    assign bus.IncPC   = strobes[IDX_INCPC];
    assign bus.MARin   = strobes[IDX_MARIN];
    assign bus.Read    = strobes[IDX_READ];
    assign bus.Write   = strobes[IDX_WRITE];
    assign bus.MDRin   = strobes[IDX_MDRIN];
    assign bus.MDRout  = strobes[IDX_MDROUT];
    assign bus.IRin    = strobes[IDX_IRIN];
    assign bus.Yin     = strobes[IDX_YIN];
    assign bus.Zin     = strobes[IDX_ZIN];
    assign bus.Zlowout = strobes[IDX_ZLOWOUT];
    assign bus.Cout    = strobes[IDX_COUT];
    assign bus.BAout   = strobes[IDX_BAOUT];
    assign bus.ADD     = strobes[IDX_ADD];
    assign bus.Gra     = strobes[IDX_GRA];
    assign bus.Grb     = strobes[IDX_GRB];
    assign bus.Rin     = strobes[IDX_RIN];
    assign bus.Rout    = strobes[IDX_ROUT];
    assign bus.CONin   = strobes[IDX_CONIN];
    assign bus.BRANCH  = strobes[IDX_BRANCH];

    assign bus.Run     = (state_q >= S_T0) && (state_q <= S_T7);
    assign bus.state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Scoreboard bench for control_unit. Each scenario task pushes the expected
// per-cycle state/strobe picture of one or more instructions into a queue
// (together with the IR value and clr level to present in that cycle), then
// pops the queue one clock at a time and compares against the DUT.
// IR is randomised in every cycle except T3, so any dependence on IR outside
// T3 shows up as a sequencing error.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic clk = 1'b0;
    logic clr = 1'b0;

    control_unit_if bus ();

    control_unit u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Strobe masks, MSB first: PCout PCin IncPC MARin Read Write MDRin MDRout
    // IRin Yin Zin Zlowout Cout BAout ADD Gra Grb Rin Rout CONin BRANCH
    localparam logic [20:0] M_PCOUT   = 21'b1 << 20;
    localparam logic [20:0] M_PCIN    = 21'b1 << 19;
    localparam logic [20:0] M_INCPC   = 21'b1 << 18;
    localparam logic [20:0] M_MARIN   = 21'b1 << 17;
    localparam logic [20:0] M_READ    = 21'b1 << 16;
    localparam logic [20:0] M_WRITE   = 21'b1 << 15;
    localparam logic [20:0] M_MDRIN   = 21'b1 << 14;
    localparam logic [20:0] M_MDROUT  = 21'b1 << 13;
    localparam logic [20:0] M_IRIN    = 21'b1 << 12;
    localparam logic [20:0] M_YIN     = 21'b1 << 11;
    localparam logic [20:0] M_ZIN     = 21'b1 << 10;
    localparam logic [20:0] M_ZLOWOUT = 21'b1 << 9;
    localparam logic [20:0] M_COUT    = 21'b1 << 8;
    localparam logic [20:0] M_BAOUT   = 21'b1 << 7;
    localparam logic [20:0] M_ADD     = 21'b1 << 6;
    localparam logic [20:0] M_GRA     = 21'b1 << 5;
    localparam logic [20:0] M_GRB     = 21'b1 << 4;
    localparam logic [20:0] M_RIN     = 21'b1 << 3;
    localparam logic [20:0] M_ROUT    = 21'b1 << 2;
    localparam logic [20:0] M_CONIN   = 21'b1 << 1;
    localparam logic [20:0] M_BRANCH  = 21'b1 << 0;
    localparam logic [20:0] M_NONE    = 21'b0;

    logic [20:0] obs;
    assign obs = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.Write,
                  bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
                  bus.Cout, bus.BAout, bus.ADD, bus.Gra, bus.Grb, bus.Rin,
                  bus.Rout, bus.CONin, bus.BRANCH};

    typedef struct {
        logic [3:0]  st;
        logic [20:0] strb;
        logic [31:0] ir;
        logic        clr_n;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    push_cnt = 0;
    int    push_lim = 99;
    string cur_tag = "";

    function automatic void begin_tag(string t, int lim);
        cur_tag  = t;
        push_cnt = 0;
        push_lim = lim;
    endfunction

    function automatic void add_e(logic [3:0] st, logic [20:0] m, logic [31:0] ir, logic clr_n);
        exp_t e;
        if (push_cnt >= push_lim) return;
        push_cnt++;
        e.st    = st;
        e.strb  = m;
        e.ir    = ir;
        e.clr_n = clr_n;
        e.tag   = cur_tag;
        sb.push_back(e);
    endfunction

    // Expected cycle-by-cycle picture of one instruction, fetch included.
    // Only the T3 entry carries the real instruction word.
    function automatic void push_instr(logic [31:0] ir, string tag, int lim);
        logic [4:0] op;
        op = ir[31:27];
        begin_tag(tag, lim);
        add_e(4'd1, M_PCOUT | M_MARIN,           $urandom, 1'b1);
        add_e(4'd2, M_INCPC | M_READ | M_MDRIN,  $urandom, 1'b1);
        add_e(4'd3, M_MDROUT | M_IRIN,           $urandom, 1'b1);
        case (op)
            5'b00000: begin // ld
                add_e(4'd4, M_GRB | M_BAOUT | M_YIN,   ir,       1'b1);
                add_e(4'd5, M_COUT | M_ADD | M_ZIN,    $urandom, 1'b1);
                add_e(4'd6, M_ZLOWOUT | M_MARIN,       $urandom, 1'b1);
                add_e(4'd7, M_READ | M_MDRIN,          $urandom, 1'b1);
                add_e(4'd8, M_MDROUT | M_GRA | M_RIN,  $urandom, 1'b1);
            end
            5'b00001: begin // ldi
                add_e(4'd4, M_GRB | M_BAOUT | M_YIN,   ir,       1'b1);
                add_e(4'd5, M_COUT | M_ADD | M_ZIN,    $urandom, 1'b1);
                add_e(4'd6, M_ZLOWOUT | M_GRA | M_RIN, $urandom, 1'b1);
            end
            5'b00010: begin // st
                add_e(4'd4, M_GRB | M_BAOUT | M_YIN,   ir,       1'b1);
                add_e(4'd5, M_COUT | M_ADD | M_ZIN,    $urandom, 1'b1);
                add_e(4'd6, M_ZLOWOUT | M_MARIN,       $urandom, 1'b1);
                add_e(4'd7, M_GRA | M_ROUT | M_MDRIN,  $urandom, 1'b1);
                add_e(4'd8, M_WRITE,                   $urandom, 1'b1);
            end
            5'b01100: begin // addi
                add_e(4'd4, M_GRB | M_ROUT | M_YIN,    ir,       1'b1);
                add_e(4'd5, M_COUT | M_ADD | M_ZIN,    $urandom, 1'b1);
                add_e(4'd6, M_ZLOWOUT | M_GRA | M_RIN, $urandom, 1'b1);
            end
            5'b10010: begin // br
                add_e(4'd4, M_GRA | M_ROUT | M_CONIN,  ir,       1'b1);
                add_e(4'd5, M_PCOUT | M_YIN,           $urandom, 1'b1);
                add_e(4'd6, M_COUT | M_ADD | M_BRANCH | M_ZIN, $urandom, 1'b1);
                add_e(4'd7, M_ZLOWOUT | M_PCIN,        $urandom, 1'b1);
            end
            5'b10100: begin // jr
                add_e(4'd4, M_GRA | M_ROUT | M_PCIN,   ir,       1'b1);
            end
            default: begin  // nop, halt, unlisted
                add_e(4'd4, M_NONE,                    ir,       1'b1);
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_non_halt();
        logic [31:0] r;
        r = $urandom;
        if (r[31:27] == 5'b11011) r[31:27] = 5'b11010;
        return r;
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        begin_tag("reset", 99);
        add_e(4'd0, M_NONE, $urandom, 1'b0);
        add_e(4'd0, M_NONE, $urandom, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_ldi();
        exp_t e;
        push_instr(32'h08800019, "ldi", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        push_instr(32'h91980019, "br", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_ld_st();
        exp_t e;
        push_instr(32'h00800004, "ld", 99);
        push_instr(32'h10800004, "st", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_jr_unknown();
        exp_t e;
        push_instr(32'hA0800000, "jr", 99);
        push_instr(32'hF8000000, "unknown", 99);
        push_instr(32'hD0000000, "nop", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    // st is cut off after its T6 cycle by one clr=0 edge; fetch then restarts.
    task automatic test_reset_mid();
        exp_t e;
        push_instr(32'h10800004, "st_cut", 7);
        begin_tag("mid_reset", 99);
        add_e(4'd0, M_NONE, $urandom, 1'b0);
        push_instr(32'h61180005, "addi_after_rst", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        push_instr(32'hD8000000, "halt", 99);
        begin_tag("halted", 99);
        for (int i = 0; i < 20; i++) add_e(4'd15, M_NONE, $urandom, 1'b1);
        begin_tag("halt_reset", 99);
        add_e(4'd0, M_NONE, $urandom, 1'b0);
        push_instr(32'h08800019, "ldi_after_halt", 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] prog [8];
        prog[0] = 32'h00800004;  // ld
        prog[1] = 32'h61180005;  // addi
        prog[2] = 32'h91980019;  // br
        prog[3] = 32'hA0800000;  // jr
        prog[4] = 32'h10800004;  // st
        prog[5] = 32'h08800019;  // ldi
        prog[6] = 32'hD0000000;  // nop
        prog[7] = 32'hF8000000;  // unlisted
        for (int i = 0; i < 8; i++) push_instr(prog[i], $sformatf("b2b%0d", i), 99);
        for (int i = 0; i < 12; i++) push_instr(rand_non_halt(), $sformatf("rnd%0d", i), 99);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            clr = e.clr_n;
            @(posedge clk); #1; bus.IRdataout = e.ir; #1;
            n_cmp++; if (bus.state !== e.st) begin n_bad++; $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st); end
            n_cmp++; if (bus.Run !== (e.st >= 4'd1 && e.st <= 4'd8)) begin n_bad++; $display("FAIL %s Run: got %b in state %0d", e.tag, bus.Run, e.st); end
            n_cmp++; if (obs !== e.strb) begin n_bad++; $display("FAIL %s strobes st%0d: got %021b want %021b", e.tag, e.st, obs, e.strb); end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        bus.IRdataout = 32'h0;
        test_reset();
        $display("reset done: %0d compared", n_cmp);
        test_ldi();
        $display("ldi done: %0d compared", n_cmp);
        test_branch();
        $display("branch done: %0d compared", n_cmp);
        test_ld_st();
        $display("ld/st done: %0d compared", n_cmp);
        test_jr_unknown();
        $display("jr/unknown/nop done: %0d compared", n_cmp);
        test_reset_mid();
        $display("mid-instruction reset done: %0d compared", n_cmp);
        test_halt();
        $display("halt done: %0d compared", n_cmp);
        test_back_to_back();
        $display("back-to-back done: %0d compared", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

endmodule
